// File: rtl/debounce_pkg.sv
// -----------------------------------------------------------------------------
// debounce_pkg
// Shared definitions for the debounce / edge-trigger conditioning stage.
//   state_e          : 2-bit acceptance FSM encoding (LOW, RISE_CHK, HIGH,
//                      FALL_CHK). The encoding is Gray-ordered around the
//                      acceptance loop.
//   SYNC_STAGES_DEF  : default synchroniser depth.
//   STABLE_CNT_DEF   : default number of identical samples to accept a level.
// -----------------------------------------------------------------------------
package debounce_pkg;

  typedef enum logic [1:0] {
    LOW      = 2'b00,
    RISE_CHK = 2'b01,
    HIGH     = 2'b11,
    FALL_CHK = 2'b10
  } state_e;

  localparam int SYNC_STAGES_DEF = 2;
  localparam int STABLE_CNT_DEF  = 4;

  // True when the debounced level is (or is being held as) high.
  function automatic logic state_is_high(input state_e st);
    return (st == HIGH) || (st == FALL_CHK);
  endfunction

endpackage : debounce_pkg

// File: rtl/sync_chain.sv
// -----------------------------------------------------------------------------
// sync_chain
// Multi-flop synchroniser for a single asynchronous bit.
//   clk   : sampling clock
//   rstn  : asynchronous active-low reset, clears every stage to 0
//   d_i   : asynchronous input bit
//   q_o   : synchronised bit, SYNC_STAGES cycles behind d_i
// Parameter SYNC_STAGES: chain depth, 2..4.
// -----------------------------------------------------------------------------
module sync_chain #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rstn,
  input  logic d_i,
  output logic q_o
);

  logic [SYNC_STAGES-1:0] sync_q;

  // Shift chain; bit 0 is the metastability-exposed first stage.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[SYNC_STAGES-1];

endmodule : sync_chain

// File: rtl/debounce_edge_trigger.sv
// -----------------------------------------------------------------------------
// debounce_edge_trigger
// Synchronises a bouncy asynchronous level, accepts a new level only after
// STABLE_CNT identical synchronised samples, and emits a one-cycle trigger on
// every accepted rising level (drives the downstream one-shot's x_in).
//
// Ports:
//   clk        : system clock, rising edge
//   rstn       : asynchronous active-low reset
//   raw_in     : asynchronous raw level
//   en         : gates trig_out / fall_out only; level tracking always runs
//   trig_out   : registered one-cycle pulse on each accepted rising level
//   level_out  : registered debounced level
//   fall_out   : registered one-cycle pulse on each accepted falling level
//                (exists only when DEBOUNCE_FALL_PULSE_EN is defined)
//
// Build option: define DEBOUNCE_FALL_PULSE_EN to add the fall_out port.
// Latency from first edge sampling a stable change to the pulse edge is
// SYNC_STAGES + STABLE_CNT edges.
// -----------------------------------------------------------------------------
module debounce_edge_trigger
  import debounce_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int STABLE_CNT  = STABLE_CNT_DEF
) (
  input  logic clk,
  input  logic rstn,
  input  logic raw_in,
  input  logic en,
  output logic trig_out,
  output logic level_out
`ifdef DEBOUNCE_FALL_PULSE_EN
  ,
  output logic fall_out
`endif
);

  localparam int CNT_W = $clog2(STABLE_CNT + 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CNT - 1);

  logic             sync_s;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             trig_q, trig_d;
  logic             level_q, level_d;
  logic             rise_accept_s;
  logic             fall_accept_s;

  sync_chain #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk (clk),
    .rstn(rstn),
    .d_i (raw_in),
    .q_o (sync_s)
  );

  // State, counter and registered outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= LOW;
      cnt_q   <= CNT_ZERO;
      trig_q  <= 1'b0;
      level_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      trig_q  <= trig_d;
      level_q <= level_d;
    end
  end

  // Next-state and stability counter. Any opposite sample in a CHK state
  // throws the partial count away, so acceptance always restarts from scratch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      LOW: begin
        if (sync_s) begin
          state_d = RISE_CHK;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d   = CNT_ZERO;
        end
      end
      RISE_CHK: begin
        if (!sync_s) begin
          state_d = LOW;
          cnt_d   = CNT_ZERO;
        end else if (cnt_q == CNT_LAST) begin
          state_d = HIGH;
          cnt_d   = CNT_ZERO;
        end else begin
          cnt_d   = cnt_q + CNT_ONE;
        end
      end
      HIGH: begin
        if (!sync_s) begin
          state_d = FALL_CHK;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d   = CNT_ZERO;
        end
      end
      FALL_CHK: begin
        if (sync_s) begin
          state_d = HIGH;
          cnt_d   = CNT_ZERO;
        end else if (cnt_q == CNT_LAST) begin
          state_d = LOW;
          cnt_d   = CNT_ZERO;
        end else begin
          cnt_d   = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = LOW;
        cnt_d   = CNT_ZERO;
      end
    endcase
  end

  // Output decode. Pulses are computed from the accepting transition, so they
  // fall back to 0 on the following edge without any extra clearing logic; a
  // pulse suppressed by en is simply never generated.
  always_comb begin
    rise_accept_s = (state_q == RISE_CHK) && sync_s && (cnt_q == CNT_LAST);
    fall_accept_s = (state_q == FALL_CHK) && !sync_s && (cnt_q == CNT_LAST);
    trig_d        = rise_accept_s && en;
    level_d       = state_is_high(state_d);
  end

`ifdef DEBOUNCE_FALL_PULSE_EN
  logic fall_q;

  // Falling-acceptance pulse register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      fall_q <= 1'b0;
    end else begin
      fall_q <= fall_accept_s && en;
    end
  end

  assign fall_out = fall_q;
`else
  logic unused_fall_s;
  assign unused_fall_s = fall_accept_s;
`endif

  assign trig_out  = trig_q;
  assign level_out = level_q;

endmodule : debounce_edge_trigger

// File: tb/tb_debounce_edge_trigger.sv
// -----------------------------------------------------------------------------
// tb_debounce_edge_trigger
// Directed bench for debounce_edge_trigger with default parameters
// (SYNC_STAGES=2, STABLE_CNT=4 -> 6-edge acceptance latency). Inputs change
// 1 time unit after a rising edge; outputs are sampled 1 unit after each edge.
// "Edge n" is the n-th rising edge after the input change.
// -----------------------------------------------------------------------------
module tb_debounce_edge_trigger;

  logic clk    = 1'b0;
  logic rstn   = 1'b0;
  logic raw_in = 1'b0;
  logic en     = 1'b1;
  logic trig_out;
  logic level_out;
`ifdef DEBOUNCE_FALL_PULSE_EN
  logic fall_out;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  debounce_edge_trigger dut (
    .clk      (clk),
    .rstn     (rstn),
    .raw_in   (raw_in),
    .en       (en),
    .trig_out (trig_out),
    .level_out(level_out)
`ifdef DEBOUNCE_FALL_PULSE_EN
    ,
    .fall_out (fall_out)
`endif
  );

  task automatic chk(input string tag, input logic obs, input logic exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic edge_chk(input string tag, input logic t_exp, input logic l_exp);
    tick();
    chk({tag, "/trig"}, trig_out, t_exp);
    chk({tag, "/level"}, level_out, l_exp);
  endtask

  initial begin
    logic [4:0] pat;

    // Reset state, then release with raw_in already high.
    #12;
    chk("rst/trig", trig_out, 1'b0);
    chk("rst/level", level_out, 1'b0);
    raw_in = 1'b1;
    rstn   = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      edge_chk($sformatf("t1_e%0d", i), (i == 6), (i >= 6));
    end

    // Asynchronous reset while HIGH clears outputs without a clock edge.
    rstn = 1'b0;
    #1;
    chk("arst_high/trig", trig_out, 1'b0);
    chk("arst_high/level", level_out, 1'b0);
    raw_in = 1'b0;
    #1;
    rstn = 1'b1;

    // Three-cycle pulse is shorter than STABLE_CNT: rejected.
    raw_in = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      edge_chk($sformatf("t2_e%0d", i), 1'b0, 1'b0);
    end
    raw_in = 1'b0;
    for (int i = 4; i <= 10; i++) begin
      edge_chk($sformatf("t2_e%0d", i), 1'b0, 1'b0);
    end

    // Bounce 1,0,1,0,1 then hold 1: final 0->1 sample on edge 5, pulse on 10.
    pat = 5'b10101;
    for (int i = 1; i <= 5; i++) begin
      raw_in = pat[i-1];
      edge_chk($sformatf("t3_e%0d", i), 1'b0, 1'b0);
    end
    for (int i = 6; i <= 12; i++) begin
      edge_chk($sformatf("t3_e%0d", i), (i == 10), (i >= 10));
    end

    // Accepted fall: level drops on edge 6 (fall pulse on same edge if built).
    raw_in = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      edge_chk($sformatf("t4f_e%0d", i), 1'b0, (i < 6));
`ifdef DEBOUNCE_FALL_PULSE_EN
      chk($sformatf("t4f_e%0d/fall", i), fall_out, (i == 6));
`endif
    end

    // en=0 during a stable rise: level follows, trigger suppressed and lost.
    en     = 1'b0;
    raw_in = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      edge_chk($sformatf("t4r_e%0d", i), 1'b0, (i >= 6));
    end
    en = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      edge_chk($sformatf("t4en_e%0d", i), 1'b0, 1'b1);
    end

    // Reset while HIGH, then again mid RISE_CHK, raw_in held high.
    rstn = 1'b0;
    #1;
    chk("t5a/trig", trig_out, 1'b0);
    chk("t5a/level", level_out, 1'b0);
    #1;
    rstn = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      edge_chk($sformatf("t5a_e%0d", i), 1'b0, 1'b0);
    end
    rstn = 1'b0;
    #1;
    chk("t5b/trig", trig_out, 1'b0);
    chk("t5b/level", level_out, 1'b0);
    #1;
    rstn = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      edge_chk($sformatf("t5b_e%0d", i), (i == 6), (i >= 6));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule : tb_debounce_edge_trigger
